// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: sends one byte MSB first to the selected chip(s),
// then holds every chip select high for a fixed gap before accepting the next byte.
module spi_byte_master #(
  parameter int SLAVE_COUNT = 1,
  parameter int CLK_DIV     = 2,
  parameter int CS_GAP      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             tx_byte,
  input  logic                   tx_byte_valid,
  input  logic [SLAVE_COUNT-1:0] ss_in,
  output logic                   spi_ready,
  output logic [SLAVE_COUNT-1:0] ss_out,
  output logic                   sclk,
  output logic                   mosi
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t           state;
  logic [6:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             tail;

  // Frame sequencer. Bit 7 goes straight to mosi at frame start, so the shift
  // register only keeps the seven bits still to be sent. After the 8th falling
  // edge, CS is held low for one more half-period (tail) so that CS stays low for
  // 17 half-periods in total and sclk is already low when CS rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      tail      <= 1'b0;
      spi_ready <= 1'b0;
      ss_out    <= '1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      spi_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_byte_valid && !(&ss_in)) begin
            shreg   <= tx_byte[6:0];
            ss_out  <= ss_in;
            mosi    <= tx_byte[7];
            div_cnt <= '0;
            bit_cnt <= '0;
            tail    <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (tail) begin
              tail      <= 1'b0;
              ss_out    <= '1;
              spi_ready <= 1'b1;
              gap_cnt   <= '0;
              state     <= GAP;
            end else if (sclk) begin
              sclk <= 1'b0;
              if (bit_cnt != 3'd7) begin
                shreg   <= {shreg[5:0], 1'b0};
                mosi    <= shreg[6];
                bit_cnt <= bit_cnt + 3'd1;
              end else begin
                mosi <= 1'b0;
                tail <= 1'b1;
              end
            end else begin
              sclk <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: table-driven frames, hand-written
// corner sequences and randomized back-to-back traffic against a frame-level model.
module tb_spi_byte_master;

  localparam int A_DIV = 2;
  localparam int A_GAP = 4;
  localparam int B_DIV = 1;
  localparam int B_GAP = 2;
  localparam int LIMIT = 500;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a_tx = 8'h00, b_tx = 8'h00;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0] a_ss = 3'b111, b_ss = 3'b111;
  logic       a_ready, b_ready, a_sclk, b_sclk, a_mosi, b_mosi;
  logic [2:0] a_ss_out, b_ss_out;

  logic       sel = 1'b0;
  logic [2:0] m_ss;
  logic       m_sclk, m_mosi, m_ready;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] bits;
    logic [2:0] ss;
    int         rises;
    int         cs_low;
    int         start;
    bit         ready_ok;
    bit         after_ok;
    bit         timeout;
  } frame_t;

  typedef struct {
    logic [7:0] tx;
    logic [2:0] ss;
    bit         exp_frame;
    logic [2:0] exp_ss;
  } vec_t;

  typedef struct {
    logic [7:0] tx;
    logic [2:0] ss;
  } expect_t;

  spi_byte_master #(.SLAVE_COUNT(3), .CLK_DIV(A_DIV), .CS_GAP(A_GAP)) dut_a (
    .clk(clk), .reset(reset), .tx_byte(a_tx), .tx_byte_valid(a_valid), .ss_in(a_ss),
    .spi_ready(a_ready), .ss_out(a_ss_out), .sclk(a_sclk), .mosi(a_mosi));

  spi_byte_master #(.SLAVE_COUNT(3), .CLK_DIV(B_DIV), .CS_GAP(B_GAP)) dut_b (
    .clk(clk), .reset(reset), .tx_byte(b_tx), .tx_byte_valid(b_valid), .ss_in(b_ss),
    .spi_ready(b_ready), .ss_out(b_ss_out), .sclk(b_sclk), .mosi(b_mosi));

  assign m_ss    = sel ? b_ss_out : a_ss_out;
  assign m_sclk  = sel ? b_sclk   : a_sclk;
  assign m_mosi  = sel ? b_mosi   : a_mosi;
  assign m_ready = sel ? b_ready  : a_ready;

  // Free-running clock and cycle counter used for frame period measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case some bounded wait was still mis-sized.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] tx, input logic [2:0] ss, input logic valid);
    a_tx    = tx;
    a_ss    = ss;
    a_valid = valid;
  endtask

  // Observes one frame on the selected DUT from the first CS-low sample until CS
  // returns high, recording MOSI at every sclk rising edge (MSB first).
  task automatic captureFrame(input bit drop_valid, output frame_t f);
    int   n = 0;
    bit   bad_ready = 0;
    logic prev_sclk = 1'b0;
    f.bits = '0; f.ss = '1; f.rises = 0; f.cs_low = 0; f.start = 0;
    f.ready_ok = 0; f.after_ok = 0; f.timeout = 0;
    while (m_ss == 3'b111 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      f.timeout = 1;
      return;
    end
    if (drop_valid) begin
      a_valid = 1'b0;
      b_valid = 1'b0;
    end
    f.ss = m_ss;
    f.start = cyc;
    while (m_ss != 3'b111 && f.cs_low < LIMIT) begin
      f.cs_low++;
      if (m_ready) bad_ready = 1;
      if (m_sclk && !prev_sclk) begin
        f.bits = {f.bits[6:0], m_mosi};
        f.rises++;
      end
      prev_sclk = m_sclk;
      @(negedge clk);
    end
    if (f.cs_low >= LIMIT) begin
      f.timeout = 1;
      return;
    end
    f.ready_ok = m_ready && !bad_ready && !m_sclk && !m_mosi;
    @(negedge clk);
    f.after_ok = (m_ss == 3'b111) && !m_ready;
  endtask

  task automatic checkFrame(input string name, input frame_t f, input logic [7:0] exp_bits,
                            input logic [2:0] exp_ss, input int exp_cs_low);
    checkOutput({name, " timeout"}, int'(f.timeout), 0);
    checkOutput({name, " mosi bits"}, int'(f.bits), int'(exp_bits));
    checkOutput({name, " ss_out"}, int'(f.ss), int'(exp_ss));
    checkOutput({name, " rising edges"}, f.rises, 8);
    checkOutput({name, " cs low cycles"}, f.cs_low, exp_cs_low);
    checkOutput({name, " spi_ready at cs rise"}, int'(f.ready_ok), 1);
    checkOutput({name, " cs high after ready"}, int'(f.after_ok), 1);
  endtask

  task automatic waitIdle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Drives every test sequence in order and prints the summary.
  initial begin
    vec_t    vecs[5];
    frame_t  f1, f2;
    expect_t refq[$];
    expect_t e;
    int      rcount, lows, highs, readies, prev_start;
    logic    p;

    vecs[0] = '{tx: 8'hA5, ss: 3'b110, exp_frame: 1, exp_ss: 3'b110};
    vecs[1] = '{tx: 8'h3C, ss: 3'b011, exp_frame: 1, exp_ss: 3'b011};
    vecs[2] = '{tx: 8'h00, ss: 3'b111, exp_frame: 0, exp_ss: 3'b111};
    vecs[3] = '{tx: 8'hFF, ss: 3'b000, exp_frame: 1, exp_ss: 3'b000};
    vecs[4] = '{tx: 8'h81, ss: 3'b101, exp_frame: 1, exp_ss: 3'b101};

    waitIdle(3);
    checkOutput("reset ss_out", int'(a_ss_out), 3'b111);
    checkOutput("reset sclk", int'(a_sclk), 0);
    checkOutput("reset mosi", int'(a_mosi), 0);
    checkOutput("reset spi_ready", int'(a_ready), 0);
    reset = 1'b0;
    waitIdle(2);

    // Table-driven single frames; valid is dropped once the frame has started.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].tx, vecs[i].ss, 1'b1);
      if (vecs[i].exp_frame) begin
        captureFrame(1'b1, f1);
        checkFrame($sformatf("vec%0d", i), f1, vecs[i].tx, vecs[i].exp_ss, 17 * A_DIV);
      end else begin
        lows = 0; highs = 0; readies = 0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (a_ss_out != 3'b111) lows++;
          if (a_sclk) highs++;
          if (a_ready) readies++;
        end
        checkOutput($sformatf("vec%0d cs low cycles", i), lows, 0);
        checkOutput($sformatf("vec%0d sclk high cycles", i), highs, 0);
        checkOutput($sformatf("vec%0d spi_ready pulses", i), readies, 0);
        a_valid = 1'b0;
      end
      waitIdle(A_GAP + 2);
    end

    // Back-to-back frames with valid held, byte stepped after spi_ready.
    applyStimulus(8'h50, 3'b101, 1'b1);
    captureFrame(1'b0, f1);
    a_tx = 8'h00;
    captureFrame(1'b0, f2);
    a_valid = 1'b0;
    checkFrame("b2b first", f1, 8'h50, 3'b101, 17 * A_DIV);
    checkFrame("b2b second", f2, 8'h00, 3'b101, 17 * A_DIV);
    checkOutput("b2b period", f2.start - f1.start, 17 * A_DIV + A_GAP + 1);
    waitIdle(A_GAP + 2);

    // Inputs changed at the 3rd rising edge must only affect the next frame.
    applyStimulus(8'hFF, 3'b110, 1'b1);
    fork
      captureFrame(1'b0, f1);
      begin
        rcount = 0;
        p = 1'b0;
        for (int k = 0; k < LIMIT && rcount < 3; k++) begin
          @(negedge clk);
          if (a_sclk && !p) rcount++;
          p = a_sclk;
        end
        a_tx = 8'h00;
        a_ss = 3'b011;
      end
    join
    captureFrame(1'b0, f2);
    a_valid = 1'b0;
    checkOutput("midframe change edge found", rcount, 3);
    checkFrame("midframe first", f1, 8'hFF, 3'b110, 17 * A_DIV);
    checkFrame("midframe next", f2, 8'h00, 3'b011, 17 * A_DIV);
    waitIdle(A_GAP + 2);

    // Reset one cycle after the 4th rising edge aborts the frame at once.
    applyStimulus(8'hC3, 3'b110, 1'b1);
    rcount = 0;
    p = 1'b0;
    for (int k = 0; k < LIMIT && rcount < 4; k++) begin
      @(negedge clk);
      if (a_sclk && !p) rcount++;
      p = a_sclk;
    end
    checkOutput("abort 4th edge found", rcount, 4);
    @(negedge clk);
    reset = 1'b1;
    a_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort ss_out", int'(a_ss_out), 3'b111);
    checkOutput("abort sclk", int'(a_sclk), 0);
    checkOutput("abort mosi", int'(a_mosi), 0);
    checkOutput("abort spi_ready", int'(a_ready), 0);
    reset = 1'b0;
    readies = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_ready) readies++;
    end
    checkOutput("abort no late spi_ready", readies, 0);
    applyStimulus(8'h96, 3'b011, 1'b1);
    captureFrame(1'b1, f1);
    checkFrame("after abort", f1, 8'h96, 3'b011, 17 * A_DIV);
    waitIdle(A_GAP + 2);

    // Fastest configuration: CLK_DIV=1, CS_GAP=2.
    sel = 1'b1;
    @(negedge clk);
    b_tx = 8'h81;
    b_ss = 3'b110;
    b_valid = 1'b1;
    captureFrame(1'b1, f1);
    checkFrame("div1", f1, 8'h81, 3'b110, 17 * B_DIV);
    waitIdle(B_GAP + 2);
    sel = 1'b0;
    @(negedge clk);

    // Randomized back-to-back traffic checked against a queue of presented bytes.
    e.tx = 8'($urandom_range(0, 255));
    e.ss = 3'($urandom_range(0, 6));
    refq.push_back(e);
    applyStimulus(e.tx, e.ss, 1'b1);
    prev_start = 0;
    for (int i = 0; i < 16; i++) begin
      captureFrame(1'b0, f1);
      if (i < 15) begin
        e.tx = 8'($urandom_range(0, 255));
        e.ss = 3'($urandom_range(0, 6));
        refq.push_back(e);
        applyStimulus(e.tx, e.ss, 1'b1);
      end else begin
        a_valid = 1'b0;
      end
      e = refq.pop_front();
      checkFrame($sformatf("rand%0d", i), f1, e.tx, e.ss, 17 * A_DIV);
      if (i > 0) checkOutput($sformatf("rand%0d period", i), f1.start - prev_start, 17 * A_DIV + A_GAP + 1);
      prev_start = f1.start;
    end
    waitIdle(A_GAP + 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
